// File: rtl/pkt_reasm_pkg.sv
// Shared types and default sizing for the multi-channel packet reassembler.
package pkt_reasm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } ctx_state_e;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_FLIT_W    = 256;
  localparam int DEF_NUM_FLITS = 4;
  localparam int DEF_DFX_W     = 2;
  localparam int DEF_TIMEOUT   = 255;

  function automatic int pkt_w(input int addr_w = DEF_ADDR_W,
                               input int flit_w = DEF_FLIT_W,
                               input int num_flits = DEF_NUM_FLITS);
    return addr_w + flit_w * num_flits;
  endfunction

endpackage

// File: rtl/pkt_reasm_ctx.sv
// One reassembly context: IDLE/COLLECT/DONE FSM, flit buffer and expected index.
// Optional idle timeout in COLLECT when PKT_REASM_TIMEOUT_EN is defined.
module pkt_reasm_ctx
  import pkt_reasm_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FLIT_W    = DEF_FLIT_W,
  parameter int NUM_FLITS = DEF_NUM_FLITS,
  parameter int IDX_W     = 2,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int PW        = ADDR_W + FLIT_W * NUM_FLITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              deliver_i,
  output ctx_state_e        state_o,
  output logic [PW-1:0]     pkt_o,
  output logic              err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLITS - 1);

  ctx_state_e        state_q, state_d;
  logic [IDX_W-1:0]  exp_q, exp_d;
  logic              store;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_q;
  logic [FLIT_W-1:0] flit_q [NUM_FLITS];

`ifdef PKT_REASM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (state_q == COLLECT) && !wr_en_i &&
                       (idle_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    idle_cnt_d = '0;
    if (state_q == COLLECT && !wr_en_i) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    store   = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en_i) begin
          if (idx_i == '0) begin
            store   = 1'b1;
            exp_d   = IDX_W'(1);
            state_d = (NUM_FLITS == 1) ? DONE : COLLECT;
          end else begin
            err_o = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (wr_en_i) begin
          if (idx_i == exp_q) begin
            store = 1'b1;
            exp_d = exp_q + 1'b1;
            if (idx_i == LAST_IDX) state_d = DONE;
          end else if (idx_i == '0) begin
            // A fresh header aborts the partial packet and restarts collection.
            store = 1'b1;
            err_o = 1'b1;
            exp_d = IDX_W'(1);
          end else begin
            err_o   = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          err_o   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (deliver_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  // Payload storage is deliberately not reset; validity is tracked by the FSM.
  always_ff @(posedge clk) begin
    if (store) begin
      flit_q[idx_i] <= data_i;
      if (idx_i == '0) addr_q <= addr_i;
    end
  end

  assign state_o            = state_q;
  assign pkt_o[ADDR_W-1:0]  = addr_q;

  for (genvar gi = 0; gi < NUM_FLITS; gi++) begin : g_flit
    assign pkt_o[ADDR_W + gi*FLIT_W +: FLIT_W] = flit_q[gi];
  end

endmodule

// File: rtl/pkt_reassembly_mc.sv
// Multi-channel packet reassembler: one context per source DFX id, round-robin
// output arbitration with grant hold under backpressure. Timeout: PKT_REASM_TIMEOUT_EN.
module pkt_reassembly_mc
  import pkt_reasm_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FLIT_W    = DEF_FLIT_W,
  parameter int NUM_FLITS = DEF_NUM_FLITS,
  parameter int DFX_W     = DEF_DFX_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  localparam int NUM_CH   = 2**DFX_W,
  localparam int IDX_W    = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1,
  localparam int PW       = pkt_w(ADDR_W, FLIT_W, NUM_FLITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flit_valid,
  output logic              flit_ready,
  input  logic [DFX_W-1:0]  flit_src_dfx,
  input  logic [IDX_W-1:0]  flit_idx,
  input  logic [ADDR_W-1:0] flit_dst_addr,
  input  logic [FLIT_W-1:0] flit_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PW-1:0]     pkt_data,
  output logic [DFX_W-1:0]  pkt_src_dfx,
  output logic              ack_ok_valid,
  output logic [DFX_W-1:0]  ack_ok_dfx,
  output logic [NUM_CH-1:0] ack_err
);

  ctx_state_e        ctx_state [NUM_CH];
  logic [PW-1:0]     ctx_pkt   [NUM_CH];
  logic [NUM_CH-1:0] done_vec, wr_en, deliver, err_vec;

  logic [DFX_W-1:0]  ptr_q, ptr_d, grant_q, grant, cand;
  logic              hold_q, found, handshake;
  logic              ack_ok_valid_q;
  logic [DFX_W-1:0]  ack_ok_dfx_q;
  logic [NUM_CH-1:0] ack_err_q;

  assign flit_ready = !done_vec[flit_src_dfx];
  assign pkt_valid  = |done_vec;
  assign handshake  = pkt_valid && pkt_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ctx
    assign wr_en[gi]    = flit_valid && flit_ready && (flit_src_dfx == DFX_W'(gi));
    assign done_vec[gi] = (ctx_state[gi] == DONE);
    assign deliver[gi]  = handshake && (grant == DFX_W'(gi));

    pkt_reasm_ctx #(
      .ADDR_W    (ADDR_W),
      .FLIT_W    (FLIT_W),
      .NUM_FLITS (NUM_FLITS),
      .IDX_W     (IDX_W),
      .TIMEOUT   (TIMEOUT),
      .PW        (PW)
    ) u_ctx (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_en[gi]),
      .idx_i     (flit_idx),
      .addr_i    (flit_dst_addr),
      .data_i    (flit_data),
      .deliver_i (deliver[gi]),
      .state_o   (ctx_state[gi]),
      .pkt_o     (ctx_pkt[gi]),
      .err_o     (err_vec[gi])
    );
  end

  // A stalled grant stays put so the presented packet cannot change under the consumer.
  always_comb begin
    grant = grant_q;
    cand  = '0;
    found = 1'b0;
    if (!hold_q) begin
      grant = ptr_q;
      for (int i = 0; i < NUM_CH; i++) begin
        cand = ptr_q + DFX_W'(i);
        if (!found && done_vec[cand]) begin
          grant = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign ptr_d = handshake ? grant + DFX_W'(1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q          <= '0;
      grant_q        <= '0;
      hold_q         <= 1'b0;
      ack_ok_valid_q <= 1'b0;
      ack_ok_dfx_q   <= '0;
      ack_err_q      <= '0;
    end else begin
      ptr_q          <= ptr_d;
      grant_q        <= grant;
      hold_q         <= pkt_valid && !pkt_ready;
      ack_ok_valid_q <= handshake;
      ack_ok_dfx_q   <= grant;
      ack_err_q      <= err_vec;
    end
  end

  assign pkt_data     = ctx_pkt[grant];
  assign pkt_src_dfx  = grant;
  assign ack_ok_valid = ack_ok_valid_q;
  assign ack_ok_dfx   = ack_ok_dfx_q;
  assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_pkt_reassembly_mc.sv
// Directed self-checking bench for pkt_reassembly_mc; covers the timeout
// behaviour for both PKT_REASM_TIMEOUT_EN settings.
module tb_pkt_reassembly_mc;

  localparam int ADDR_W = 10;
  localparam int FLIT_W = 256;
  localparam int NF     = 4;
  localparam int DFX_W  = 2;
  localparam int PW     = ADDR_W + FLIT_W * NF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flit_valid = 1'b0;
  logic              flit_ready;
  logic [DFX_W-1:0]  flit_src_dfx = '0;
  logic [1:0]        flit_idx = '0;
  logic [ADDR_W-1:0] flit_dst_addr = '0;
  logic [FLIT_W-1:0] flit_data = '0;
  logic              pkt_valid;
  logic              pkt_ready = 1'b0;
  logic [PW-1:0]     pkt_data;
  logic [DFX_W-1:0]  pkt_src_dfx;
  logic              ack_ok_valid;
  logic [DFX_W-1:0]  ack_ok_dfx;
  logic [3:0]        ack_err;

  int checks = 0;
  int failures = 0;

  pkt_reassembly_mc #(.TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flit_valid    (flit_valid),
    .flit_ready    (flit_ready),
    .flit_src_dfx  (flit_src_dfx),
    .flit_idx      (flit_idx),
    .flit_dst_addr (flit_dst_addr),
    .flit_data     (flit_data),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_data      (pkt_data),
    .pkt_src_dfx   (pkt_src_dfx),
    .ack_ok_valid  (ack_ok_valid),
    .ack_ok_dfx    (ack_ok_dfx),
    .ack_err       (ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [ADDR_W-1:0] a, input logic [FLIT_W-1:0] base);
    logic [PW-1:0] r;
    r = '0;
    r[ADDR_W-1:0] = a;
    for (int k = 0; k < NF; k++) r[ADDR_W + k*FLIT_W +: FLIT_W] = base + FLIT_W'(k);
    return r;
  endfunction

  // Offer one flit from a negedge and hold it until the first rising edge with flit_ready.
  task automatic send(input int dfx, input int idx, input logic [ADDR_W-1:0] a, input logic [FLIT_W-1:0] d);
    int n;
    @(negedge clk);
    flit_valid    = 1'b1;
    flit_src_dfx  = DFX_W'(dfx);
    flit_idx      = 2'(idx);
    flit_dst_addr = a;
    flit_data     = d;
    #1;
    n = 0;
    while (!flit_ready && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $error("FAIL flit_accept_wait observed=stalled expected=accepted dfx=%0d idx=%0d", dfx, idx);
    end
    @(posedge clk);
    #1;
    flit_valid    = 1'b0;
    flit_dst_addr = '1;
  endtask

  task automatic send_pkt(input int dfx, input logic [ADDR_W-1:0] a, input logic [FLIT_W-1:0] base);
    for (int k = 0; k < NF; k++) send(dfx, k, (k == 0) ? a : '1, base + FLIT_W'(k));
  endtask

  task automatic deliver(input string tag, input int dfx, input logic [PW-1:0] exp);
    @(negedge clk);
    chk({tag, "_pkt_valid"}, PW'(pkt_valid), PW'(1));
    chk({tag, "_pkt_src"}, PW'(pkt_src_dfx), PW'(dfx));
    chk({tag, "_pkt_data"}, pkt_data, exp);
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    pkt_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_ok_valid"}, PW'(ack_ok_valid), PW'(1));
    chk({tag, "_ack_ok_dfx"}, PW'(ack_ok_dfx), PW'(dfx));
  endtask

  initial begin : stim
    bit seen;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pkt_valid", PW'(pkt_valid), PW'(0));
    chk("rst_ack_ok", PW'(ack_ok_valid), PW'(0));
    chk("rst_ack_err", PW'(ack_err), PW'(0));
    chk("rst_flit_ready", PW'(flit_ready), PW'(1));
    $display("step reset: pkt_valid=%0d ack_err=%b", pkt_valid, ack_err);

    // Sequential packet on dfx 1
    for (int k = 0; k < NF - 1; k++) send(1, k, (k == 0) ? 10'h005 : 10'h3FF, 256'hA0 + 256'(k));
    @(negedge clk);
    chk("seq_pre_last_valid", PW'(pkt_valid), PW'(0));
    send(1, 3, 10'h3FF, 256'hA3);
    @(negedge clk);
    chk("seq_latency_valid", PW'(pkt_valid), PW'(1));
    flit_src_dfx = 2'd1;
    #1;
    chk("seq_ready_done", PW'(flit_ready), PW'(0));
    deliver("seq", 1, mk_pkt(10'h005, 256'hA0));
    @(negedge clk);
    chk("seq_ack_ok_pulse", PW'(ack_ok_valid), PW'(0));
    $display("step sequential: dfx1 delivered");

    // Interleaved dfx 1 and dfx 3 with the output stalled
    for (int k = 0; k < NF; k++) begin
      send(1, k, (k == 0) ? 10'h005 : 10'h3FF, 256'h150 + 256'(k));
      if (k == NF - 1) begin
        @(negedge clk);
        chk("intl_first_src", PW'(pkt_src_dfx), PW'(1));
      end
      send(3, k, (k == 0) ? 10'h007 : 10'h3FF, 256'h370 + 256'(k));
    end
    @(negedge clk);
    chk("intl_hold_src", PW'(pkt_src_dfx), PW'(1));
    deliver("intl_1", 1, mk_pkt(10'h005, 256'h150));
    deliver("intl_3", 3, mk_pkt(10'h007, 256'h370));
    $display("step interleave: dfx1 then dfx3 delivered");

    // Backpressure: dfx 0 and dfx 2 both DONE, pointer at 0
    send_pkt(0, 10'h000, 256'hB0);
    send_pkt(2, 10'h002, 256'hC0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pkt_src_dfx !== 2'd0 || pkt_data !== mk_pkt(10'h000, 256'hB0) || pkt_valid !== 1'b1) seen = 1'b1;
    end
    chk("bp_stable", PW'(seen), PW'(0));
    chk("bp_src", PW'(pkt_src_dfx), PW'(0));
    flit_valid = 1'b1; flit_idx = 2'd0; flit_src_dfx = 2'd0;
    #1;
    chk("bp_ready_dfx0", PW'(flit_ready), PW'(0));
    flit_src_dfx = 2'd2;
    #1;
    chk("bp_ready_dfx2", PW'(flit_ready), PW'(0));
    flit_valid = 1'b0;
    deliver("bp_0", 0, mk_pkt(10'h000, 256'hB0));
    deliver("bp_2", 2, mk_pkt(10'h002, 256'hC0));
    $display("step backpressure: dfx0 then dfx2 delivered");

    // Out-of-order index on dfx 2, then a stray index on idle dfx 1
    send(2, 0, 10'h022, 256'hD0);
    send(2, 1, 10'h3FF, 256'hD1);
    send(2, 3, 10'h3FF, 256'hD3);
    @(negedge clk);
    chk("err_ack_err", PW'(ack_err), PW'(4'b0100));
    chk("err_no_pkt", PW'(pkt_valid), PW'(0));
    @(negedge clk);
    chk("err_pulse_width", PW'(ack_err), PW'(0));
    send(1, 2, 10'h3FF, 256'h12);
    @(negedge clk);
    chk("err_idle_idx", PW'(ack_err), PW'(4'b0010));
    send_pkt(2, 10'h022, 256'hE0);
    deliver("err_recover", 2, mk_pkt(10'h022, 256'hE0));
    $display("step error: dfx2 recovered");

    // Idle timeout inside a packet on dfx 0
    send(0, 0, 10'h0AA, 256'hF0);
    send(0, 1, 10'h3FF, 256'hF1);
`ifdef PKT_REASM_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (ack_err[0] === 1'b1) seen = 1'b1;
    end
    chk("tmo_seen", PW'(seen), PW'(1));
    chk("tmo_delay", PW'(n), PW'(8));
    send_pkt(0, 10'h0AA, 256'hF0);
    deliver("tmo_after", 0, mk_pkt(10'h0AA, 256'hF0));
`else
    seen = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ack_err !== 4'b0000) seen = 1'b1;
      n++;
    end
    chk("tmo_none", PW'(seen), PW'(0));
    send(0, 2, 10'h3FF, 256'hF2);
    send(0, 3, 10'h3FF, 256'hF3);
    deliver("tmo_late", 0, mk_pkt(10'h0AA, 256'hF0));
`endif
    $display("step timeout: idle cycles=%0d", n);

    // Reset with dfx 1 mid-packet and dfx 3 DONE
    send_pkt(3, 10'h033, 256'h30);
    send(1, 0, 10'h011, 256'h10);
    send(1, 1, 10'h3FF, 256'h11);
    @(negedge clk);
    chk("rst2_pre_valid", PW'(pkt_valid), PW'(1));
    rst_n = 1'b0;
    #1;
    chk("rst2_valid_async", PW'(pkt_valid), PW'(0));
    chk("rst2_ack_err", PW'(ack_err), PW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_idle_valid", PW'(pkt_valid), PW'(0));
    send(1, 2, 10'h3FF, 256'h12);
    @(negedge clk);
    chk("rst2_partial_gone", PW'(ack_err), PW'(4'b0010));
    send_pkt(3, 10'h044, 256'h40);
    deliver("rst2_fresh", 3, mk_pkt(10'h044, 256'h40));
    $display("step reset_mid: dfx3 fresh packet delivered");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
